// File: rtl/minimax_rf_pkg.sv
// Shared definitions for the minimax register-file sequencer: controller
// state encoding, register-file geometry and default data width.
package minimax_rf_pkg;

   localparam int NUM_REGS     = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int XLEN_DEFAULT = 32;
   // Wide enough for any legal debug wait limit (1..15).
   localparam int WAIT_W       = 4;

   typedef enum logic [1:0] {
      SCRUB = 2'd0,
      RUN   = 2'd1,
      DBG   = 2'd2,
      ACK   = 2'd3
   } rf_state_e;

endpackage

// File: rtl/minimax_rf_scrub.sv
// Post-reset scrubber: walks x1..x31 one register per clock, raising a
// write strobe for each, then sets a sticky done flag.
// Only instantiated when MINIMAX_RF_CTRL_SCRUB_EN is defined.
module minimax_rf_scrub
   import minimax_rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [REG_ADDR_W-1:0] idx,
   output logic                  we,
   output logic                  last,
   output logic                  done
);

   localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

   logic [REG_ADDR_W-1:0] idx_q, idx_d;
   logic                  done_q, done_d;

   // Strobe is held low while reset is asserted so the file sees no write
   // until the scrub actually starts.
   assign we   = ~done_q & ~reset;
   assign last = we & (idx_q == LAST_IDX);
   assign idx  = idx_q;
   assign done = done_q;

   // Advance the index while scrubbing; finishing the last register latches done.
   always_comb begin
      idx_d  = idx_q;
      done_d = done_q;
      if (!done_q) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == LAST_IDX) done_d = 1'b1;
      end
   end

   // Index and done flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= REG_ADDR_W'(1);
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

endmodule

// File: rtl/minimax_rf_ctrl.sv
// Sequencer owning minimax_rf's address/write port. Optionally scrubs the
// file after reset, then passes core traffic through and time-shares the
// file with a debug host using a level request / one-cycle ack handshake.
// Optional scrub: define MINIMAX_RF_CTRL_SCRUB_EN.
module minimax_rf_ctrl
   import minimax_rf_pkg::*;
#(
   parameter int DBG_WAIT = 4,   // legal 1..15
   parameter int XLEN     = XLEN_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] core_addrS,
   input  logic [REG_ADDR_W-1:0] core_addrD,
   input  logic [XLEN-1:0]       core_wdata,
   input  logic                  core_we,
   output logic [XLEN-1:0]       core_rS,
   output logic [XLEN-1:0]       core_rD,
   output logic                  core_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   input  logic [XLEN-1:0]       dbg_wdata,
   output logic                  dbg_ack,
   output logic [XLEN-1:0]       dbg_rdata,
   output logic [REG_ADDR_W-1:0] rf_addrS,
   output logic [REG_ADDR_W-1:0] rf_addrD,
   output logic [XLEN-1:0]       rf_new_value,
   output logic                  rf_we,
   input  logic [XLEN-1:0]       rf_rS,
   input  logic [XLEN-1:0]       rf_rD,
   output logic                  scrub_done
);

   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(DBG_WAIT);

   rf_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;

`ifdef MINIMAX_RF_CTRL_SCRUB_EN
   localparam rf_state_e RESET_STATE = SCRUB;

   logic [REG_ADDR_W-1:0] scrub_idx;
   logic                  scrub_we;
   logic                  scrub_last;
   logic                  scrub_done_w;

   minimax_rf_scrub u_scrub (
      .clk   (clk),
      .reset (reset),
      .idx   (scrub_idx),
      .we    (scrub_we),
      .last  (scrub_last),
      .done  (scrub_done_w)
   );

   assign scrub_done = scrub_done_w;
`else
   localparam rf_state_e RESET_STATE = RUN;

   logic scrub_done_q, scrub_done_d;

   // No scrub: report done from the first edge after reset.
   always_comb scrub_done_d = 1'b1;

   // Done flag register for the scrub-less build.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) scrub_done_q <= 1'b0;
      else       scrub_done_q <= scrub_done_d;
   end

   assign scrub_done = scrub_done_q;
`endif

   assign dbg_rdata = dbg_rdata_q;

   // Next state and port muxing; the core owns the file unless told otherwise.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = '0;
      dbg_rdata_d  = dbg_rdata_q;
      rf_addrS     = core_addrS;
      rf_addrD     = core_addrD;
      rf_new_value = core_wdata;
      rf_we        = core_we;
      core_rS      = rf_rS;
      core_rD      = rf_rD;
      core_stall   = 1'b0;
      dbg_ack      = 1'b0;
      case (state_q)
`ifdef MINIMAX_RF_CTRL_SCRUB_EN
         SCRUB: begin
            rf_addrS     = '0;
            rf_addrD     = scrub_idx;
            rf_new_value = '0;
            rf_we        = scrub_we;
            core_rS      = '0;
            core_rD      = '0;
            core_stall   = 1'b1;
            if (scrub_last) state_d = RUN;
         end
`endif
         RUN: begin
            // An idle core cycle hands over at once. Otherwise each busy
            // cycle is counted, and once the count has reached the limit the
            // handover is forced; the core write in that cycle still lands.
            // This gives the worst-case request-to-ack of DBG_WAIT+2.
            if (dbg_req) begin
               if (!core_we || (wait_cnt_q == WAIT_LIM)) state_d = DBG;
               else wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         DBG: begin
            rf_addrS     = dbg_addr;
            rf_addrD     = dbg_addr;
            rf_new_value = dbg_wdata;
            rf_we        = dbg_we;
            core_rS      = '0;
            core_rD      = '0;
            core_stall   = 1'b1;
            if (!dbg_we) dbg_rdata_d = rf_rS;
            state_d      = ACK;
         end
         ACK: begin
            // Core runs normally here; the request is not re-sampled.
            dbg_ack = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // State, wait counter and debug read-data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RESET_STATE;
         wait_cnt_q  <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_minimax_rf_ctrl.sv
// Self-checking bench for minimax_rf_ctrl with a behavioural register file.
// Debug completions are checked by a scoreboard monitor; other checks are
// inline. Covers both builds via MINIMAX_RF_CTRL_SCRUB_EN.
module tb_minimax_rf_ctrl;

   localparam int XLEN = 32;
`ifdef MINIMAX_RF_CTRL_SCRUB_EN
   localparam logic STALL_RST = 1'b1;
`else
   localparam logic STALL_RST = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [4:0]      core_addrS, core_addrD;
   logic [XLEN-1:0] core_wdata;
   logic            core_we;
   logic [XLEN-1:0] core_rS, core_rD;
   logic            core_stall;
   logic            dbg_req, dbg_we;
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_wdata;
   logic            dbg_ack;
   logic [XLEN-1:0] dbg_rdata;
   logic [4:0]      rf_addrS, rf_addrD;
   logic [XLEN-1:0] rf_new_value;
   logic            rf_we;
   logic [XLEN-1:0] rf_rS, rf_rD;
   logic            scrub_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [XLEN-1:0] rdata;
      int              cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   minimax_rf_ctrl #(.DBG_WAIT(4), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .core_addrS(core_addrS), .core_addrD(core_addrD),
      .core_wdata(core_wdata), .core_we(core_we),
      .core_rS(core_rS), .core_rD(core_rD), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .rf_addrS(rf_addrS), .rf_addrD(rf_addrD), .rf_new_value(rf_new_value),
      .rf_we(rf_we), .rf_rS(rf_rS), .rf_rD(rf_rD), .scrub_done(scrub_done)
   );

   // Behavioural minimax_rf: x0 reads zero, combinational reads, clocked write.
   // Seeded with nonzero junk so the scrub has something to clear.
   logic [XLEN-1:0] regs [32];
   bit seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'hA5A5_0000 | i;
         seeded <= 1'b1;
      end else if (rf_we && rf_addrD != 5'd0) begin
         regs[rf_addrD] <= rf_new_value;
      end
   end
   assign rf_rS = (rf_addrS == 5'd0) ? '0 : regs[rf_addrS];
   assign rf_rD = (rf_addrD == 5'd0) ? '0 : regs[rf_addrD];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every ack must match the oldest expected completion.
   always @(negedge clk) begin
      if (dbg_ack) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_rdata", dbg_rdata, e.rdata);
            check("ack_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic check_reset_vals();
      check("reset_outputs", {core_stall, dbg_ack, dbg_rdata, rf_we, scrub_done},
            {STALL_RST, 1'b0, 32'h0, 1'b0, 1'b0});
`ifdef MINIMAX_RF_CTRL_SCRUB_EN
      check("reset_scrub_idx", rf_addrD, 5'd1);
`endif
   endtask

   // Called just after reset release; leaves time at negedge of first RUN cycle.
   task automatic post_reset();
`ifdef MINIMAX_RF_CTRL_SCRUB_EN
      logic [XLEN-1:0] acc;
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         check("scrub_cycle", {rf_we, rf_addrD, rf_new_value, core_stall, scrub_done},
               {1'b1, 5'(i), 32'h0, 1'b1, 1'b0});
      end
      @(negedge clk);
      check("scrub_done_run", {scrub_done, core_stall}, 2'b10);
      acc = '0;
      for (int i = 1; i < 32; i++) acc |= regs[i];
      check("scrub_zeroed", acc, 32'h0);
`else
      @(negedge clk);
      check("noscrub_first", {scrub_done, core_stall, rf_we}, 3'b000);
      @(negedge clk);
      check("noscrub_done", {scrub_done, core_stall, rf_we}, 3'b100);
`endif
   endtask

   // Issue one debug access from a RUN cycle (called at posedge+1).
   task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [XLEN-1:0] wd,
                          input logic [XLEN-1:0] exp_rd, input int lat);
      exp_t e;
      int   stalls = 0;
      bit   got    = 1'b0;
      dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
      e.rdata = exp_rd;
      e.cyc   = cyc + lat;
      sb.push_back(e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (core_stall) begin
            stalls++;
            check("dbg_rf_port", {rf_we, rf_addrS, rf_addrD, rf_new_value}, {we, addr, addr, wd});
            check("dbg_core_iso", {core_rS, core_rD}, 64'h0);
         end
         if (dbg_ack) begin
            got = 1'b1;
            break;
         end
      end
      check("dbg_ack_seen", got, 1'b1);
      check("dbg_stall_cycles", stalls, 1);
      @(posedge clk); #1;
      dbg_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      core_addrS = '0; core_addrD = '0; core_wdata = '0; core_we = 1'b0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals();

`ifdef MINIMAX_RF_CTRL_SCRUB_EN
      // Abort a scrub in its 10th cycle; it must restart from x1.
      @(posedge clk); #1 reset = 1'b0;
      repeat (9) @(negedge clk);
      @(negedge clk);
      check("scrub_cycle10_idx", rf_addrD, 5'd10);
      reset = 1'b1;
      #1 check_reset_vals();
`endif
      @(posedge clk); #1 reset = 1'b0;
      post_reset();
      @(posedge clk); #1;

      // Core writes x5, then debug reads it back.
      core_addrD = 5'd5; core_wdata = 32'hDEADBEEF; core_we = 1'b1;
      @(posedge clk); #1 core_we = 1'b0;
      dbg_txn(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 2);
      // Back-to-back debug write; read data stays from the previous read.
      dbg_txn(1'b1, 5'd7, 32'h12345678, 32'hDEADBEEF, 2);
      core_addrS = 5'd7; core_addrD = 5'd5;
      @(negedge clk);
      check("core_read_after_dbg", {core_stall, core_rS, core_rD}, {1'b0, 32'h12345678, 32'hDEADBEEF});
      @(posedge clk); #1;
      // x0: write is a no-op, read returns zero, timing unchanged.
      dbg_txn(1'b1, 5'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 2);
      dbg_txn(1'b0, 5'd0, 32'h0, 32'h0, 2);
      // Forced handover: core writes every cycle, ack at req+DBG_WAIT+2.
      dbg_txn(1'b1, 5'd20, 32'h0, 32'h0, 2);
      core_addrD = 5'd20; core_wdata = 32'hCAFE0020; core_we = 1'b1;
      dbg_txn(1'b0, 5'd20, 32'h0, 32'hCAFE0020, 6);
      core_we = 1'b0;
      // Wait counter must have cleared: idle read is back to 2 cycles.
      dbg_txn(1'b0, 5'd7, 32'h0, 32'h12345678, 2);

      // Reset during DBG: no ack, outputs back to reset values at once.
      dbg_we = 1'b0; dbg_addr = 5'd5; dbg_req = 1'b1;
      @(posedge clk); #1;
      check("dbg_entered", core_stall, 1'b1);
      #2 reset = 1'b1;
      #1 check_reset_vals();
      dbg_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      post_reset();
      @(posedge clk); #1;
`ifdef MINIMAX_RF_CTRL_SCRUB_EN
      dbg_txn(1'b0, 5'd5, 32'h0, 32'h0, 2);
      dbg_txn(1'b1, 5'd9, 32'h9, 32'h0, 2);
`else
      dbg_txn(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 2);
      dbg_txn(1'b1, 5'd9, 32'h9, 32'hDEADBEEF, 2);
`endif

      repeat (4) @(posedge clk);
      #1 check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
